// File: rtl/dac_generator_ad56x3.sv
// dac_generator_ad56x3: ramp generator streaming samples into a 24-bit AD56x3 SPI frame driver; ports clk, reset in; dacSync, dacSclk, dacDin out
module dac_generator_ad56x3 #(
  parameter string SIGN_A = "UNSIGNED",
  parameter string SIGN_B = "UNSIGNED",
  parameter int DATA_WIDTH = 14,
  parameter int INCREASE_RATE = 1
) (
  input logic clk,
  input logic reset,
  output logic dacSync,
  output logic dacSclk,
  output logic dacDin
);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  localparam bit sgn_a = (SIGN_A == "SIGNED");
  localparam bit sgn_b = (SIGN_B == "SIGNED");
  state_t state;
  logic [DATA_WIDTH-1:0] cnt, asoData, asiData, conv;
  logic ch, asoValid, asiValid, asoChannel, asiChannel, asoRdy, asiRdy, gen_xfer, drv_xfer;
  logic [23:0] word, sh;
  logic [5:0] cyc;
  always_comb begin
    asoValid = ~reset;
    asoChannel = ch;
    asoData = ch ? ~cnt : cnt;
    asiValid = asoValid;
    asiChannel = asoChannel;
    asiData = asoData;
    asiRdy = ~reset & (state == IDLE);
    asoRdy = asiRdy;
    gen_xfer = asoValid & asoRdy;
    drv_xfer = asiValid & asiRdy;
    conv = asiData ^ {(asiChannel ? sgn_b : sgn_a), {(DATA_WIDTH-1){1'b0}}};
    word = {5'b00011, 2'b00, asiChannel, 16'(conv) << (16 - DATA_WIDTH)};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      ch <= 1'b0;
      sh <= '0;
      cyc <= '0;
      dacSync <= 1'b1;
      dacSclk <= 1'b1;
      dacDin <= 1'b0;
    end else begin
      if (gen_xfer) begin
        ch <= ~ch;
        if (ch) cnt <= cnt + DATA_WIDTH'(INCREASE_RATE);
      end
      case (state)
        IDLE: if (drv_xfer) begin
          state <= SHIFT;
          sh <= {word[22:0], 1'b0};
          cyc <= '0;
          dacSync <= 1'b0;
          dacSclk <= 1'b1;
          dacDin <= word[23];
        end
        SHIFT: begin
          cyc <= cyc + 6'd1;
          if (!cyc[0]) dacSclk <= 1'b0;
          else if (cyc == 6'd47) begin
            state <= GAP;
            cyc <= '0;
            dacSync <= 1'b1;
            dacSclk <= 1'b1;
            dacDin <= 1'b0;
          end else begin
            dacSclk <= 1'b1;
            dacDin <= sh[23];
            sh <= {sh[22:0], 1'b0};
          end
        end
        GAP: begin
          cyc <= cyc + 6'd1;
          if (cyc[0]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dac_generator_ad56x3.sv
// tb_dac_generator_ad56x3: random reset stimulus on three parameterisations, pins decoded and compared against an arithmetic frame model
module tb_dac_generator_ad56x3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic longint ref_raw(int n, int dw, int inc);
    longint m = longint'(1) << dw;
    longint c = (longint'(n / 2) * inc) % m;
    return (n % 2 == 1) ? m - 1 - c : c;
  endfunction
  function automatic logic [23:0] ref_word(int n, int dw, int inc, bit sg);
    longint r = ref_raw(n, dw, inc);
    if (sg) r = r ^ (longint'(1) << (dw - 1));
    return 24'h180000 | (24'(n % 2) << 16) | 24'((r << (16 - dw)) & 'hFFFF);
  endfunction
  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int DW = g == 0 ? 14 : g == 1 ? 12 : 16;
    localparam int INC = g == 0 ? 1 : g == 1 ? 1000 : 'h1234;
    localparam bit SG = (g == 1);
    logic sync, sclk, din;
    if (g == 1) begin : s
      dac_generator_ad56x3 #(.SIGN_A("SIGNED"), .SIGN_B("SIGNED"), .DATA_WIDTH(DW), .INCREASE_RATE(INC)) dut (
        .clk(clk), .reset(reset), .dacSync(sync), .dacSclk(sclk), .dacDin(din));
    end else begin : s
      dac_generator_ad56x3 #(.SIGN_A("UNSIGNED"), .SIGN_B("UNSIGNED"), .DATA_WIDTH(DW), .INCREASE_RATE(INC)) dut (
        .clk(clk), .reset(reset), .dacSync(sync), .dacSclk(sclk), .dacDin(din));
    end
    int cyc = 0;
    int n = 0;
    int exp_start = 0;
    int low = 0;
    int bits = 0;
    bit rp = 1'b1, ps = 1'b1, psc = 1'b1, pd = 1'b0, active = 1'b0, fell;
    logic [23:0] word = '0;
    always @(negedge clk) begin
      cyc++;
      if (rp) begin
        n = 0;
        active = 1'b0;
        exp_start = cyc + 1;
        check($sformatf("i%0d_reset_pins", g), {sync, sclk, din}, 3'b110);
      end
      fell = ps && !sync;
      if (fell || cyc == exp_start) check($sformatf("i%0d_frame_start", g), fell, cyc == exp_start);
      if (fell) begin
        active = 1'b1;
        n++;
        low = 0;
        bits = 0;
        word = '0;
        exp_start = cyc + 51;
      end
      if (active && !sync) begin
        low++;
        if (psc && !sclk) begin
          bits++;
          word = {word[22:0], pd};
          check($sformatf("i%0d_din_stable", g), din, pd);
        end
      end
      if (active && sync && !ps) begin
        check($sformatf("i%0d_sync_low_clks", g), low, 48);
        check($sformatf("i%0d_sclk_falls", g), bits, 24);
        check($sformatf("i%0d_frame_word", g), word, ref_word(n - 1, DW, INC, SG));
        active = 1'b0;
      end
      if (sync) check($sformatf("i%0d_sclk_idle", g), sclk, 1);
      check($sformatf("i%0d_valid", g), s.dut.asoValid, !reset);
      check($sformatf("i%0d_rdy", g), s.dut.asiRdy, !reset && cyc + 1 == exp_start);
      if (!reset) begin
        check($sformatf("i%0d_data", g), s.dut.asoData, ref_raw(n, DW, INC));
        check($sformatf("i%0d_channel", g), s.dut.asoChannel, n % 2);
      end
      rp = reset;
      ps = sync;
      psc = sclk;
      pd = din;
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (700) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (28) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (120) @(posedge clk);
    for (int i = 0; i < 25; i++) begin
      #2 reset = 1'b1;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #2 reset = 1'b0;
      repeat ($urandom_range(1, 300)) @(posedge clk);
    end
    repeat (2) @(posedge clk);
    #1 $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
